seq_ctrl: RTL and testbench
===========================

SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand bit count and the number of serial cycles per arithmetic instruction (2..255).
REQ-002 The block SHALL have parameter STALL_CYCLES, default 2, giving the number of cycles a STALL instruction holds (1..15).
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port o_pc, output, 3 bits: program counter driven to the instruction memory address input.
REQ-006 The block SHALL have port i_instr, input, 3 bits: opcode returned combinationally by the instruction memory for o_pc.
REQ-007 The block SHALL have port i_switch, input, 1 bit: asynchronous user run switch.
REQ-008 The block SHALL have port o_op, output, 2 bits: 00 none, 01 mult y,d; 10 mult x,1-d; 11 add y,x.
REQ-009 The block SHALL have port o_start, output, 1 bit: one-cycle pulse on the first serial cycle of an arithmetic instruction.
REQ-010 The block SHALL have port o_shift_en, output, 1 bit: datapath bit-serial shift enable.
REQ-011 The block SHALL have port o_wait, output, 1 bit: high while blocked on the switch.

Function
REQ-012 The block SHALL decode opcodes as follows: 000 NOP, 001 STALL, 010 MULYD, 011 MULX1D, 100 ADDYX, 101 reserved (executes as NOP), 110 WAITOFF, 111 WAITON.
REQ-013 The block SHALL implement the states FETCH, SERIAL, STALL and WAITSW, and SHALL sample i_instr only in FETCH.
REQ-014 The block SHALL synchronise i_switch through two flops, giving 2-cycle latency; all switch references below mean the synchronised value.
REQ-015 For NOP and 101 in FETCH, the block SHALL set pc to pc+1 and remain in FETCH, taking 1 cycle.
REQ-016 For STALL in FETCH, the block SHALL load cnt with STALL_CYCLES-1 and enter STALL; in STALL it SHALL decrement cnt and, at cnt==0, set pc to pc+1 and return to FETCH, taking STALL_CYCLES+1 cycles in total.
REQ-017 For 010, 011 and 100 in FETCH, the block SHALL latch o_op, load cnt with WIDTH-1 and enter SERIAL.
REQ-018 In SERIAL, o_shift_en SHALL be 1 for exactly WIDTH cycles and o_start SHALL be 1 only in the first of them.
REQ-019 At cnt==0 in SERIAL, the block SHALL set pc to pc+1, clear o_op to 00 and enter FETCH, taking WIDTH+1 cycles in total.
REQ-020 For WAITON and WAITOFF in FETCH, the block SHALL enter WAITSW with o_wait=1.
REQ-021 In WAITSW, when switch==1 for WAITON or switch==0 for WAITOFF, the block SHALL set pc to pc+1, clear o_wait and enter FETCH.
REQ-022 In WAITSW, the block SHALL evaluate the condition every cycle, including the first cycle after entry, so an already-satisfied condition costs exactly 2 cycles.
REQ-023 The block SHALL increment pc modulo 8 (7+1 = 0), with no halt state.
REQ-024 o_op, o_start and o_shift_en SHALL be 0 outside SERIAL.

Reset
REQ-025 When i_rst is asserted, the block SHALL force immediately, independent of i_clk: state=FETCH, pc=0, cnt=0, o_op=00, o_start=0, o_shift_en=0, o_wait=0, and both synchroniser flops=0.
REQ-026 While i_rst is high, the block SHALL neither advance pc nor act on i_instr.
REQ-027 After i_rst is released, the first decode SHALL happen on the first rising i_clk edge at which i_rst is low.
REQ-028 Reset asserted mid-SERIAL, mid-STALL or mid-WAITSW SHALL abort the instruction with no further o_shift_en.

Configuration
REQ-029 The macro SEQ_OPCNT_EN SHALL control an operation counter.
REQ-030 When SEQ_OPCNT_EN is defined, the block SHALL add output o_op_count, 8 bits, reset to 0, which increments once per completed SERIAL instruction on the cycle it returns to FETCH and saturates at 255.
REQ-031 When SEQ_OPCNT_EN is undefined, the port and counter SHALL be absent, with all other behaviour identical.

Verification
REQ-032 Reset then switch=0 with program 000,111,001,010,001,011,100,110 -> pc steps 0->1, then holds at 1 with o_wait=1; raise switch -> pc=2 within 3 cycles.
REQ-033 STALL at pc=2, STALL_CYCLES=2 -> pc=2 for exactly 3 cycles, then pc=3.
REQ-034 MULYD, WIDTH=8 -> o_op=01, o_shift_en high exactly 8 cycles, o_start high 1 cycle, pc advances on cycle 9.
REQ-035 WAITOFF at pc=7 with switch=1 -> pc holds 7; drop switch -> pc wraps to 0 and executes 000.
REQ-036 Assert i_rst on the 4th cycle of SERIAL -> o_shift_en=0, o_op=00 and pc=0 with no clock edge; release -> clean restart at pc=0.
REQ-037 With SEQ_OPCNT_EN defined, one full program pass -> o_op_count=3; 100 passes -> o_op_count=255 and holds.

Source files
------------

// File: rtl/seq_ctrl.sv
// Microsequencer: fetches 3-bit opcodes, drives a bit-serial datapath, stalls and waits on a run switch.
// Optional operation counter enabled by defining SEQ_OPCNT_EN (adds o_op_count).
module seq_ctrl #(
  parameter int WIDTH        = 8,
  parameter int STALL_CYCLES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  output logic [2:0] o_pc,
  input  logic [2:0] i_instr,
  input  logic       i_switch,
  output logic [1:0] o_op,
  output logic       o_start,
  output logic       o_shift_en,
  output logic       o_wait
`ifdef SEQ_OPCNT_EN
  ,
  output logic [7:0] o_op_count
`endif
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_SERIAL = 2'd1,
    S_STALL  = 2'd2,
    S_WAITSW = 2'd3
  } state_t;

  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_STALL   = 3'b001;
  localparam logic [2:0] OP_MULYD   = 3'b010;
  localparam logic [2:0] OP_MULX1D  = 3'b011;
  localparam logic [2:0] OP_ADDYX   = 3'b100;
  localparam logic [2:0] OP_WAITOFF = 3'b110;
  localparam logic [2:0] OP_WAITON  = 3'b111;

  localparam logic [7:0] CNT_SERIAL = 8'(WIDTH - 1);
  localparam logic [7:0] CNT_STALL  = 8'(STALL_CYCLES - 1);

  state_t     state_q;
  logic [2:0] pc_q;
  logic [7:0] cnt_q;
  logic [1:0] op_q;
  logic       start_q;
  logic       shift_q;
  logic       wait_q;
  logic       wait_on_q;
  logic       sw_s1_q;
  logic       sw_s2_q;
  logic [2:0] pc_d;
`ifdef SEQ_OPCNT_EN
  logic [7:0] opcnt_q;
`endif

  // 3-bit add wraps 7 -> 0 on its own
  assign pc_d = pc_q + 3'd1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_FETCH;
      pc_q      <= 3'd0;
      cnt_q     <= 8'd0;
      op_q      <= 2'b00;
      start_q   <= 1'b0;
      shift_q   <= 1'b0;
      wait_q    <= 1'b0;
      wait_on_q <= 1'b0;
      sw_s1_q   <= 1'b0;
      sw_s2_q   <= 1'b0;
`ifdef SEQ_OPCNT_EN
      opcnt_q   <= 8'd0;
`endif
    end else begin
      sw_s1_q <= i_switch;
      sw_s2_q <= sw_s1_q;
      start_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          case (i_instr)
            OP_STALL: begin
              cnt_q   <= CNT_STALL;
              state_q <= S_STALL;
            end
            OP_MULYD, OP_MULX1D, OP_ADDYX: begin
              op_q    <= (i_instr == OP_MULYD)  ? 2'b01 :
                         (i_instr == OP_MULX1D) ? 2'b10 : 2'b11;
              cnt_q   <= CNT_SERIAL;
              start_q <= 1'b1;
              shift_q <= 1'b1;
              state_q <= S_SERIAL;
            end
            OP_WAITOFF, OP_WAITON: begin
              wait_on_q <= i_instr[0];
              wait_q    <= 1'b1;
              state_q   <= S_WAITSW;
            end
            default: pc_q <= pc_d;  // NOP and reserved 101
          endcase
        end
        S_STALL: begin
          if (cnt_q == 8'd0) begin
            pc_q    <= pc_d;
            state_q <= S_FETCH;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_SERIAL: begin
          if (cnt_q == 8'd0) begin
            pc_q    <= pc_d;
            op_q    <= 2'b00;
            shift_q <= 1'b0;
            state_q <= S_FETCH;
`ifdef SEQ_OPCNT_EN
            if (opcnt_q != 8'hFF) opcnt_q <= opcnt_q + 8'd1;
`endif
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_WAITSW: begin
          // condition is re-evaluated every cycle, including the first one
          if (sw_s2_q == wait_on_q) begin
            pc_q    <= pc_d;
            wait_q  <= 1'b0;
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign o_pc       = pc_q;
  assign o_op       = op_q;
  assign o_start    = start_q;
  assign o_shift_en = shift_q;
  assign o_wait     = wait_q;
`ifdef SEQ_OPCNT_EN
  assign o_op_count = opcnt_q;
`endif

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed bench for seq_ctrl: run-length cycle table over a full program pass plus reset/wait corner sequences.
module tb_seq_ctrl;
  logic       clk;
  logic       rst;
  logic [2:0] pc;
  logic [2:0] instr;
  logic       sw;
  logic [1:0] op;
  logic       start;
  logic       shen;
  logic       wt;
`ifdef SEQ_OPCNT_EN
  logic [7:0] opcnt;
`endif

  logic [2:0] prog [8];
  int checks = 0;
  int errors = 0;

  assign instr = prog[pc];

  seq_ctrl #(.WIDTH(8), .STALL_CYCLES(2)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .o_pc       (pc),
    .i_instr    (instr),
    .i_switch   (sw),
    .o_op       (op),
    .o_start    (start),
    .o_shift_en (shen),
    .o_wait     (wt)
`ifdef SEQ_OPCNT_EN
    ,
    .o_op_count (opcnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc, op, start, shift_en, wait}
  wire [7:0] obs = {pc, op, start, shen, wt};

  typedef struct {
    logic       sw;
    int         n;
    logic [2:0] pc;
    logic [1:0] op;
    logic       st;
    logic       sh;
    logic       wt;
  } vec_t;

  vec_t tbl [21];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step_chk(input string name, input logic [7:0] exp);
    @(posedge clk);
    #1;
    check(name, obs, exp);
  endtask

  initial begin
    // Program: NOP, WAITON, STALL, MULYD, STALL, MULX1D, ADDYX, WAITOFF
    prog[0] = 3'b000; prog[1] = 3'b111; prog[2] = 3'b001; prog[3] = 3'b010;
    prog[4] = 3'b001; prog[5] = 3'b011; prog[6] = 3'b100; prog[7] = 3'b110;

    //            sw  n  pc  op   st  sh  wt
    tbl[0]  = '{1'b0, 1, 3'd1, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 3, 3'd1, 2'd0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 2, 3'd1, 2'd0, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1, 3'd2, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 2, 3'd2, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1, 3'd3, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1, 3'd3, 2'd1, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 7, 3'd3, 2'd1, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1, 3'd4, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 2, 3'd4, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1, 3'd5, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1, 3'd5, 2'd2, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 7, 3'd5, 2'd2, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 1, 3'd6, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1, 3'd6, 2'd3, 1'b1, 1'b1, 1'b0};
    tbl[15] = '{1'b1, 7, 3'd6, 2'd3, 1'b0, 1'b1, 1'b0};
    tbl[16] = '{1'b1, 1, 3'd7, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 2, 3'd7, 2'd0, 1'b0, 1'b0, 1'b1};
    tbl[18] = '{1'b0, 2, 3'd7, 2'd0, 1'b0, 1'b0, 1'b1};
    tbl[19] = '{1'b0, 1, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[20] = '{1'b0, 1, 3'd1, 2'd0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    sw  = 1'b0;
    #1;
    check("reset_state", obs, 8'h00);
`ifdef SEQ_OPCNT_EN
    check("opcnt_reset", opcnt, 8'd0);
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", obs, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 21; v++) begin
      for (int c = 0; c < tbl[v].n; c++) begin
        sw = tbl[v].sw;
        step_chk($sformatf("tbl%0d_c%0d", v, c),
                 {tbl[v].pc, tbl[v].op, tbl[v].st, tbl[v].sh, tbl[v].wt});
      end
    end
`ifdef SEQ_OPCNT_EN
    check("opcnt_one_pass", opcnt, 8'd3);
`endif

    // Reset in the 4th SERIAL cycle must clear outputs without a clock edge
    prog[0] = 3'b010;
    rst = 1'b1;
    #1;
    check("rst_async_idle", obs, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    step_chk("ser_c1", {3'd0, 2'd1, 1'b1, 1'b1, 1'b0});
    step_chk("ser_c2", {3'd0, 2'd1, 1'b0, 1'b1, 1'b0});
    step_chk("ser_c3", {3'd0, 2'd1, 1'b0, 1'b1, 1'b0});
    step_chk("ser_c4", {3'd0, 2'd1, 1'b0, 1'b1, 1'b0});
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_serial", obs, 8'h00);
    step_chk("rst_no_advance", 8'h00);
    @(negedge clk);
    rst = 1'b0;
    step_chk("restart_pc0", {3'd0, 2'd1, 1'b1, 1'b1, 1'b0});

    // Already-satisfied WAITON costs two cycles; 101 behaves as NOP
    rst = 1'b1;
    prog[0] = 3'b000; prog[1] = 3'b111; prog[2] = 3'b101; prog[3] = 3'b000;
    sw = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    step_chk("wsat_nop", {3'd1, 2'd0, 1'b0, 1'b0, 1'b0});
    step_chk("wsat_enter", {3'd1, 2'd0, 1'b0, 1'b0, 1'b1});
    step_chk("wsat_exit", {3'd2, 2'd0, 1'b0, 1'b0, 1'b0});
    step_chk("reserved_nop", {3'd3, 2'd0, 1'b0, 1'b0, 1'b0});

`ifdef SEQ_OPCNT_EN
    // Saturation: all-ADDYX program completes one op every 9 cycles
    rst = 1'b1;
    for (int i = 0; i < 8; i++) prog[i] = 3'b100;
    #1;
    check("opcnt_rst2", opcnt, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2400) @(posedge clk);
    #1;
    check("opcnt_sat", opcnt, 8'd255);
    repeat (30) @(posedge clk);
    #1;
    check("opcnt_sat_hold", opcnt, 8'd255);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
